// File: rtl/clock_disp_pkg.sv
// Shared constants and helpers for the time-of-day seven-segment display stage.
// Segment patterns are active-high, bit0 = a ... bit6 = g.
package clock_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam logic [2:0] DIG_SEC_ONES = 3'd0;
    localparam logic [2:0] DIG_SEC_TENS = 3'd1;
    localparam logic [2:0] DIG_MIN_ONES = 3'd2;
    localparam logic [2:0] DIG_MIN_TENS = 3'd3;
    localparam logic [2:0] DIG_HR_ONES  = 3'd4;
    localparam logic [2:0] DIG_HR_TENS  = 3'd5;

    typedef struct packed {
        logic       err;
        logic [3:0] tens;
        logic [3:0] ones;
    } split_t;

    // Repeated compare-subtract of ten; six rounds cover every 6-bit value.
    function automatic split_t split_field(input logic [5:0] value, input logic [5:0] max_value);
        split_t     r;
        logic [5:0] rem;
        rem    = value;
        r.tens = 4'd0;
        for (int k = 0; k < 6; k++) begin
            if (rem >= 6'd10) begin
                rem    = rem - 6'd10;
                r.tens = r.tens + 4'd1;
            end
        end
        r.ones = 4'(rem);
        r.err  = (value > max_value);
        return r;
    endfunction

endpackage

// File: rtl/clock_seg_display_seg7_encode.sv
// Decimal digit to active-high seven-segment pattern; the dash flag overrides the digit.
module seg7_encode
    import clock_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dash,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        if (dash) begin
            pattern = SEG_DASH;
        end else begin
            case (digit)
                4'd0:    pattern = SEG_0;
                4'd1:    pattern = SEG_1;
                4'd2:    pattern = SEG_2;
                4'd3:    pattern = SEG_3;
                4'd4:    pattern = SEG_4;
                4'd5:    pattern = SEG_5;
                4'd6:    pattern = SEG_6;
                4'd7:    pattern = SEG_7;
                4'd8:    pattern = SEG_8;
                4'd9:    pattern = SEG_9;
                default: pattern = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/clock_seg_display.sv
// Six-digit multiplexed HH MM SS display driver with a per-frame input snapshot,
// anti-ghosting guard interval and a colon that blinks with the seconds.
module clock_seg_display
    import clock_disp_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int GUARD_CYC      = 4,
    parameter int LZ_SUPPRESS    = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    input  logic       blank,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] digit_idx
);

    localparam int               SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int               DIV_W     = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] GUARD_END = DIV_W'(GUARD_CYC);
    localparam logic [5:0]       AN_OFF    = (AN_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;
    localparam logic [6:0]       SEG_DARK  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic             DP_DARK   = (SEG_ACTIVE_LOW != 0);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       digit_idx_q, digit_idx_d;
    logic [5:0]       sec_sh_q, sec_sh_d, min_sh_q, min_sh_d;
    logic [4:0]       hour_sh_q, hour_sh_d;
    logic             first_q, first_d;
    logic [5:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             terminal, load;
    logic [5:0]       sec_v, min_v;
    logic [4:0]       hour_v;
    split_t           sec_s, min_s, hr_s;
    logic [3:0]       enc_digit;
    logic             enc_dash;
    logic [6:0]       enc_pattern;
    logic [5:0]       an_on;
    logic             dp_on, lead_dark;

    always_comb begin
        terminal    = (div_cnt_q == DIV_LAST);
        div_cnt_d   = terminal ? '0 : div_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (terminal) begin
            digit_idx_d = (digit_idx_q == DIG_HR_TENS) ? DIG_SEC_ONES : digit_idx_q + 3'd1;
        end
        load      = first_q || (terminal && digit_idx_q == DIG_HR_TENS);
        sec_sh_d  = load ? sec  : sec_sh_q;
        min_sh_d  = load ? min  : min_sh_q;
        hour_sh_d = load ? hour : hour_sh_q;
        first_d   = 1'b0;
    end

    // On the first cycle out of reset the shadows are loading; show that value directly.
    always_comb begin
        sec_v  = first_q ? sec  : sec_sh_q;
        min_v  = first_q ? min  : min_sh_q;
        hour_v = first_q ? hour : hour_sh_q;
        sec_s  = split_field(sec_v, 6'd59);
        min_s  = split_field(min_v, 6'd59);
        hr_s   = split_field({1'b0, hour_v}, 6'd23);

        enc_digit = 4'd0;
        enc_dash  = 1'b0;
        case (digit_idx_q)
            DIG_SEC_ONES: begin enc_digit = sec_s.ones; enc_dash = sec_s.err; end
            DIG_SEC_TENS: begin enc_digit = sec_s.tens; enc_dash = sec_s.err; end
            DIG_MIN_ONES: begin enc_digit = min_s.ones; enc_dash = min_s.err; end
            DIG_MIN_TENS: begin enc_digit = min_s.tens; enc_dash = min_s.err; end
            DIG_HR_ONES:  begin enc_digit = hr_s.ones;  enc_dash = hr_s.err;  end
            DIG_HR_TENS:  begin enc_digit = hr_s.tens;  enc_dash = hr_s.err;  end
            default:      begin enc_digit = 4'd0;       enc_dash = 1'b0;      end
        endcase
    end

    seg7_encode u_encode (
        .digit   (enc_digit),
        .dash    (enc_dash),
        .pattern (enc_pattern)
    );

    always_comb begin
        lead_dark = (LZ_SUPPRESS != 0) && (hr_s.tens == 4'd0) && !hr_s.err;
        an_on     = 6'd1 << digit_idx_q;
        if (blank || (div_cnt_q < GUARD_END) || (digit_idx_q == DIG_HR_TENS && lead_dark)) begin
            an_on = 6'd0;
        end
        dp_on = !sec_v[0] && (digit_idx_q == DIG_MIN_ONES || digit_idx_q == DIG_HR_ONES);
        an_d  = (AN_ACTIVE_LOW != 0)  ? ~an_on       : an_on;
        seg_d = (SEG_ACTIVE_LOW != 0) ? ~enc_pattern : enc_pattern;
        dp_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_on       : dp_on;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt_q   <= '0;
            digit_idx_q <= DIG_SEC_ONES;
            sec_sh_q    <= 6'd0;
            min_sh_q    <= 6'd0;
            hour_sh_q   <= 5'd0;
            first_q     <= 1'b1;
            an_q        <= AN_OFF;
            seg_q       <= SEG_DARK;
            dp_q        <= DP_DARK;
        end else begin
            div_cnt_q   <= div_cnt_d;
            digit_idx_q <= digit_idx_d;
            sec_sh_q    <= sec_sh_d;
            min_sh_q    <= min_sh_d;
            hour_sh_q   <= hour_sh_d;
            first_q     <= first_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_idx = digit_idx_q;

endmodule

// File: doc/clock_seg_display.md
Name: clock_seg_display

Overview:
Downstream display stage for the time-of-day counter. It consumes the binary hour/min/sec fields and drives a six-digit, time-multiplexed seven-segment display (HH MM SS) with a blinking colon. Inputs are captured once per scan frame so a frame never mixes old and new time. Scan timing is derived from the system clock.

Parameters:
CLK_HZ, 50_000_000, system clock frequency.
SCAN_HZ, 1000, digit slot rate; SCAN_DIV = CLK_HZ/SCAN_HZ cycles per digit slot; SCAN_DIV must be at least 8.
GUARD_CYC, 4, anode-off cycles at the start of each slot for anti-ghosting; must be less than SCAN_DIV.
LZ_SUPPRESS, 1, 1 = hour-tens digit dark when it is 0.
SEG_ACTIVE_LOW, 1, polarity of seg and dp.
AN_ACTIVE_LOW, 1, polarity of an.

Ports:
clock  in  1  system clock.
reset  in  1  reset, asynchronous, active-high.
sec  in  6  seconds, binary, valid range 0..59.
min  in  6  minutes, binary, valid range 0..59.
hour  in  5  hours, binary, valid range 0..23.
blank  in  1  1 = all anodes inactive; scanning continues.
an  out  6  digit enables; bit i = digit i; digit 0 is rightmost.
seg  out  7  segments; bit0 = a ... bit6 = g.
dp  out  1  decimal point, used as the colon.
digit_idx  out  3  current slot, 0..5, for debug and verification.

Behaviour:
- Reset (async):
  - div_cnt=0, digit_idx=0.
  - Shadow sec/min/hour=0.
  - an, seg, dp all at their inactive level. With the default active-low settings: an=6'h3F, seg=7'h7F, dp=1.
- Slot timer:
  - div_cnt counts 0..SCAN_DIV-1.
  - At the terminal count it wraps to 0 and digit_idx advances 0→1→…→5→0.
- Frame snapshot:
  - In the cycle digit_idx wraps 5→0, the shadow registers load sec/min/hour.
  - Shadows also load on the first cycle after reset deassertion.
  - Input changes at any other time are not shown until the next frame.
- Digit map (from shadows):
  - 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens, 4 = hour ones, 5 = hour tens.
  - Tens/ones are formed by bounded compare-subtract. No divider.
- Range check:
  - sec > 59, min > 59 or hour > 23: both digits of that field show a dash (segment g only).
  - Other fields are unaffected.
- Leading zero: if LZ_SUPPRESS=1 and hour tens = 0, the anode for digit 5 stays inactive for the whole slot.
- Segment codes (active-high, before polarity): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40.
- Colon: dp is active on digits 2 and 4 when shadow sec is even; otherwise inactive.
- Output timing:
  - an, seg and dp are registered; they reflect digit_idx with 1-cycle latency.
  - For div_cnt < GUARD_CYC, an is all inactive; seg and dp already carry the new digit.
  - For the remaining cycles of the slot, exactly one anode is active.
- blank: an goes all inactive on the cycle after blank is sampled high and resumes on the cycle after it is sampled low. div_cnt, digit_idx and the snapshot continue unaffected.
- Reset mid-slot: outputs go inactive immediately; scanning restarts at digit 0 with a fresh snapshot.

Decomposition:
- Package clock_disp_pkg:
  - Segment code constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF).
  - Digit index constants (DIG_SEC_ONES..DIG_HR_TENS).
  - Function for the tens/ones split with range flag.
- Sub-module seg7_encode: combinational 4-bit digit + dash flag → 7-bit active-high pattern.
- Scan timer, snapshot, muxing, polarity and output registers stay in the top level.

Test Plan:
All scenarios use CLK_HZ=1000, SCAN_HZ=100 (SCAN_DIV=10), GUARD_CYC=4, defaults otherwise.
1. Reset asserted mid-slot → an=3F, seg=7F, dp=1 asynchronously. After release, digit_idx=0 and div_cnt=0.
2. hour=12, min=34, sec=56 → digit 0 slot: cycles 0-3 an=3F, cycles 4-9 an=3E, seg=~7D (6). Digit 5 slot: an=1F, seg=~06. Digits 2 and 4: dp=0 (sec even).
3. hour=5, LZ_SUPPRESS=1 → an=3F for all of slot 5. Slot 4 shows seg=~6D.
4. min=60, sec=7 → digits 2 and 3 show seg=~40. Digit 0 shows seg=~07. dp=1 on digits 2 and 4 (sec odd).
5. Change hour 12→13 while digit_idx=2 → slot 4 in that frame still shows 2. The next frame shows 3.
6. blank high for 25 cycles → an=3F from the next cycle; digit_idx keeps advancing. After blank drops, the active anode matches the current digit_idx.
